// File: rtl/slave_rd_arbiter.sv
// Round-robin read arbiter: drains one slave message at a time into a single
// byte stream framed as HDR, ADDR, LEN, data..., CHK over a one-byte output slot.
module slave_rd_arbiter #(
    parameter int         N   = 2,
    parameter logic [7:0] HDR = 8'hAA
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic [N-1:0]   have_msg_bus,
    input  logic [N*8-1:0] len_bus,
    input  logic [N*8-1:0] slave_data_bus,
    output logic [N-1:0]   rdreq_bus,
    output logic [7:0]     tx_data,
    output logic           tx_valid,
    input  logic           tx_ready,
    output logic           busy
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SEND_HDR  = 3'd1;
    localparam logic [2:0] SEND_ADDR = 3'd2;
    localparam logic [2:0] SEND_LEN  = 3'd3;
    localparam logic [2:0] SEND_DATA = 3'd4;
    localparam logic [2:0] SEND_CHK  = 3'd5;

    logic [2:0]   state;
    logic [7:0]   ptr;
    logic [7:0]   sel;
    logic [7:0]   len;
    logic [7:0]   count;
    logic [7:0]   chk;
    logic [N-1:0] eligible;
    logic         found;
    logic [7:0]   pick;
    logic [7:0]   pick_len;
    logic [7:0]   data_byte;
    logic [N-1:0] sel_onehot;
    int           idx;

    function automatic logic [N-1:0] onehot(input logic [7:0] s);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(s) == i) r[i] = 1'b1;
        end
        return r;
    endfunction

    // A slave being popped this cycle has not yet dropped have_msg; mask it so a
    // zero-length frame cannot be re-selected before the pop takes effect.
    always_comb begin
        eligible = have_msg_bus & ~rdreq_bus;
        found    = 1'b0;
        pick     = 8'd0;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = 8'(idx);
            end
        end
    end

    assign pick_len   = len_bus[int'(pick)*8 +: 8];
    assign data_byte  = slave_data_bus[int'(sel)*8 +: 8];
    assign sel_onehot = onehot(sel);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            ptr       <= 8'd0;
            sel       <= 8'd0;
            len       <= 8'd0;
            count     <= 8'd0;
            chk       <= 8'd0;
            tx_data   <= 8'd0;
            tx_valid  <= 1'b0;
            rdreq_bus <= '0;
        end else begin
            rdreq_bus <= '0;
            if (tx_valid && tx_ready) tx_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (found) begin
                        sel   <= pick;
                        len   <= pick_len;
                        count <= pick_len;
                        chk   <= 8'd0;
                        ptr   <= (pick == 8'(N - 1)) ? 8'd0 : pick + 8'd1;
                        state <= SEND_HDR;
                    end
                end
                SEND_HDR: begin
                    if (!tx_valid) begin
                        tx_data  <= HDR;
                        tx_valid <= 1'b1;
                        state    <= SEND_ADDR;
                    end
                end
                SEND_ADDR: begin
                    if (!tx_valid) begin
                        tx_data  <= sel;
                        tx_valid <= 1'b1;
                        chk      <= chk ^ sel;
                        state    <= SEND_LEN;
                    end
                end
                SEND_LEN: begin
                    if (!tx_valid) begin
                        tx_data  <= len;
                        tx_valid <= 1'b1;
                        chk      <= chk ^ len;
                        state    <= (len != 8'd0) ? SEND_DATA : SEND_CHK;
                    end
                end
                SEND_DATA: begin
                    if (!tx_valid) begin
                        tx_data   <= data_byte;
                        tx_valid  <= 1'b1;
                        chk       <= chk ^ data_byte;
                        count     <= count - 8'd1;
                        rdreq_bus <= sel_onehot;
                        if (count == 8'd1) state <= SEND_CHK;
                    end
                end
                SEND_CHK: begin
                    if (!tx_valid) begin
                        tx_data  <= chk;
                        tx_valid <= 1'b1;
                        // Empty messages still need one pop so the slave releases them.
                        if (len == 8'd0) rdreq_bus <= sel_onehot;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slave_rd_arbiter.sv
// Scoreboard bench for slave_rd_arbiter with two modelled slaves.
module tb_slave_rd_arbiter;

    logic        clk;
    logic        n_rst;
    logic [1:0]  have_msg_bus;
    logic [15:0] len_bus;
    logic [15:0] slave_data_bus;
    logic [1:0]  rdreq_bus;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;

    slave_rd_arbiter #(.N(2), .HDR(8'hAA)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .have_msg_bus   (have_msg_bus),
        .len_bus        (len_bus),
        .slave_data_bus (slave_data_bus),
        .rdreq_bus      (rdreq_bus),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .busy           (busy)
    );

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int rdy_mode = 0;

    logic [7:0] exp_q[$];
    logic [1:0] rq_q[$];

    logic [7:0] mlen [2];
    logic [7:0] mdata [2][4];
    logic [1:0] pos [2];
    logic [1:0] pending;
    logic [1:0] ld_req;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            have_msg_bus[i]          = pending[i];
            len_bus[i*8 +: 8]        = mlen[i];
            slave_data_bus[i*8 +: 8] = mdata[i][pos[i]];
        end
    end

    // Slave model: pops on rdreq, drops have_msg after the last byte.
    initial begin
        pending = 2'b00;
        pos[0] = 2'd0;
        pos[1] = 2'd0;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (ld_req[i]) begin
                    pending[i] <= 1'b1;
                    pos[i]     <= 2'd0;
                end else if (rdreq_bus[i] && pending[i]) begin
                    if (8'(pos[i]) + 8'd1 >= mlen[i]) pending[i] <= 1'b0;
                    else pos[i] <= pos[i] + 2'd1;
                end
            end
        end
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // Monitor: every accepted byte and every rdreq cycle is matched against the queues.
    initial begin
        logic [7:0] eb;
        logic [1:0] er;
        forever begin
            @(negedge clk);
            if (n_rst) begin
                if (tx_valid && tx_ready) begin
                    acc_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL tx_byte unexpected: got %02h, queue empty", tx_data);
                    end else begin
                        eb = exp_q.pop_front();
                        if (tx_data !== eb) begin
                            errors++;
                            $display("FAIL tx_byte: got %02h expected %02h", tx_data, eb);
                        end
                    end
                end
                if (rdreq_bus != 2'b00) begin
                    checks++;
                    if (rq_q.size() == 0) begin
                        errors++;
                        $display("FAIL rdreq unexpected: got %b, queue empty", rdreq_bus);
                    end else begin
                        er = rq_q.pop_front();
                        if (rdreq_bus !== er) begin
                            errors++;
                            $display("FAIL rdreq: got %b expected %b", rdreq_bus, er);
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", nm, got, exp);
        end
    endtask

    task automatic set_msg(input int s, input logic [7:0] n,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        mlen[s]     = n;
        mdata[s][0] = b0;
        mdata[s][1] = b1;
        mdata[s][2] = b2;
        mdata[s][3] = 8'h00;
    endtask

    task automatic fire(input logic [1:0] m);
        ld_req = m;
        @(posedge clk);
        #1;
        ld_req = 2'b00;
    endtask

    task automatic expect_frame(input logic [7:0] s, input logic [7:0] n,
                                input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] c;
        logic [7:0] d [3];
        d[0] = b0; d[1] = b1; d[2] = b2;
        exp_q.push_back(8'hAA);
        exp_q.push_back(s);
        exp_q.push_back(n);
        c = s ^ n;
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(d[i]);
            c = c ^ d[i];
            rq_q.push_back(s[0] ? 2'b10 : 2'b01);
        end
        exp_q.push_back(c);
        if (n == 8'd0) rq_q.push_back(s[0] ? 2'b10 : 2'b01);
    endtask

    task automatic wait_done(input string nm);
        bit done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(posedge clk);
            if (exp_q.size() == 0 && rq_q.size() == 0 && !busy && !tx_valid) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: bytes left %0d, rdreq left %0d", nm, exp_q.size(), rq_q.size());
            exp_q.delete();
            rq_q.delete();
        end
        @(negedge clk);
        check({nm, "_busy_low"}, {7'd0, busy}, 8'd0);
    endtask

    task automatic wait_acc(input int target, input string nm);
        bit done = 0;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(posedge clk);
            if (acc_cnt >= target) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s accept wait: got %0d bytes, required %0d", nm, acc_cnt, target);
        end
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    initial begin
        int base;
        int rq_seen;
        bit stable;
        ld_req = 2'b00;
        set_msg(0, 8'd0, 8'h00, 8'h00, 8'h00);
        set_msg(1, 8'd0, 8'h00, 8'h00, 8'h00);
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", {7'd0, tx_valid}, 8'd0);
        check("rst_tx_data", tx_data, 8'd0);
        check("rst_rdreq", {6'd0, rdreq_bus}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Single slave, one data byte.
        set_msg(0, 8'd1, 8'h01, 8'h00, 8'h00);
        expect_frame(8'd0, 8'd1, 8'h01, 8'h00, 8'h00);
        fire(2'b01);
        wait_done("single");

        // Both slaves from ptr 0: slave0 then slave1.
        do_reset();
        set_msg(0, 8'd1, 8'h01, 8'h00, 8'h00);
        set_msg(1, 8'd1, 8'h0A, 8'h00, 8'h00);
        expect_frame(8'd0, 8'd1, 8'h01, 8'h00, 8'h00);
        expect_frame(8'd1, 8'd1, 8'h0A, 8'h00, 8'h00);
        fire(2'b11);
        wait_done("both");

        // Zero-length message on slave1.
        set_msg(1, 8'd0, 8'h00, 8'h00, 8'h00);
        expect_frame(8'd1, 8'd0, 8'h00, 8'h00, 8'h00);
        fire(2'b10);
        wait_done("len0");

        // Three bytes under random tx_ready.
        set_msg(0, 8'd3, 8'h11, 8'h22, 8'h33);
        expect_frame(8'd0, 8'd3, 8'h11, 8'h22, 8'h33);
        rdy_mode = 1;
        fire(2'b01);
        wait_done("len3_random");
        rdy_mode = 0;

        // ptr is 1 now: slave1 wins; stall its first data byte for 10 cycles.
        set_msg(1, 8'd2, 8'h5A, 8'hC3, 8'h00);
        set_msg(0, 8'd1, 8'h01, 8'h00, 8'h00);
        expect_frame(8'd1, 8'd2, 8'h5A, 8'hC3, 8'h00);
        expect_frame(8'd0, 8'd1, 8'h01, 8'h00, 8'h00);
        base = acc_cnt;
        fire(2'b11);
        wait_acc(base + 3, "bp");
        #1;
        rdy_mode = 2;
        @(posedge clk);
        stable = 1;
        rq_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!tx_valid || tx_data !== 8'h5A) stable = 0;
            if (rdreq_bus != 2'b00) rq_seen++;
        end
        check("bp_stable", {7'd0, stable}, 8'd1);
        check("bp_rdreq_pulses", 8'(rq_seen), 8'd1);
        rdy_mode = 0;
        wait_done("bp");

        // Reset during SEND_DATA, then a clean frame.
        set_msg(0, 8'd3, 8'hAB, 8'hCD, 8'hEF);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h03);
        exp_q.push_back(8'hAB);
        rq_q.push_back(2'b01);
        base = acc_cnt;
        fire(2'b01);
        wait_acc(base + 4, "abort");
        #1;
        n_rst = 1'b0;
        @(negedge clk);
        check("abort_tx_valid", {7'd0, tx_valid}, 8'd0);
        check("abort_tx_data", tx_data, 8'd0);
        check("abort_rdreq", {6'd0, rdreq_bus}, 8'd0);
        check("abort_busy", {7'd0, busy}, 8'd0);
        check("abort_queue_drained", 8'(exp_q.size() + rq_q.size()), 8'd0);
        exp_q.delete();
        rq_q.delete();
        set_msg(0, 8'd1, 8'h77, 8'h00, 8'h00);
        fire(2'b01);
        @(negedge clk);
        check("abort_rdreq_in_reset", {6'd0, rdreq_bus}, 8'd0);
        expect_frame(8'd0, 8'd1, 8'h77, 8'h00, 8'h00);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        wait_done("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
